seq_shift_unit: RTL

- Multi-cycle shift/rotate unit for the MCP datapath, shifting STEP bit positions per clock under a start/done handshake.
- Gives a registered, cycle-accounted companion to the combinational shifter; the MCP control FSM holds in its execute state until done.
- Adds rotates and fixes arithmetic-right sign fill for every shift count.

---
 rtl/seq_shift_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_shift_unit
// Purpose  : Multi-cycle shift/rotate unit, STEP bit positions per clock,
//            start/done handshake. Optional carry_out via SEQ_SHIFT_CARRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_shift_unit #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] in_data,
    input  logic [2:0]  sel,
    input  logic [5:0]  k,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
`ifdef SEQ_SHIFT_CARRY_EN
    ,
    output logic        carry_out
`endif
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [2:0] c_OP_LSL = 3'd0;
    localparam logic [2:0] c_OP_LSR = 3'd1;
    localparam logic [2:0] c_OP_ASL = 3'd2;
    localparam logic [2:0] c_OP_ASR = 3'd3;
    localparam logic [2:0] c_OP_ROL = 3'd4;
    localparam logic [2:0] c_OP_ROR = 3'd5;

    localparam logic [5:0] c_STEP = 6'(STEP);

    logic [1:0]  r_state;
    logic [31:0] r_work;
    logic [2:0]  r_sel;
    logic        r_sign;
    logic [5:0]  r_count;
    logic [31:0] r_out_data;
    logic        r_busy;
    logic        r_done;

    logic [5:0]  w_eff_count;
    logic [5:0]  w_n;
    logic [5:0]  w_inv_n;
    logic [31:0] w_shl;
    logic [31:0] w_shr;
    logic [31:0] w_fill;
    logic [31:0] w_work_next;
    logic        w_last_step;

    // Shifts saturate at 32 so the stepping reaches all-fill; rotates wrap.
    always_comb begin
        w_eff_count = 6'd0;
        if (sel <= c_OP_ASR) begin
            w_eff_count = (k > 6'd32) ? 6'd32 : k;
        end else if (sel == c_OP_ROL || sel == c_OP_ROR) begin
            w_eff_count = {1'b0, k[4:0]};
        end
    end

    assign w_n         = (r_count < c_STEP) ? r_count : c_STEP;
    assign w_inv_n     = 6'd32 - w_n;
    assign w_last_step = (r_count <= c_STEP);
    assign w_shl       = r_work << w_n;
    assign w_shr       = r_work >> w_n;
    assign w_fill      = ~(32'hFFFF_FFFF >> w_n);

    always_comb begin
        w_work_next = r_work;
        case (r_sel)
            c_OP_LSL, c_OP_ASL: w_work_next = w_shl;
            c_OP_LSR:           w_work_next = w_shr;
            c_OP_ASR:           w_work_next = w_shr | (r_sign ? w_fill : 32'h0);
            c_OP_ROL:           w_work_next = w_shl | (r_work >> w_inv_n);
            c_OP_ROR:           w_work_next = w_shr | (r_work << w_inv_n);
            default:            w_work_next = r_work;
        endcase
    end

`ifdef SEQ_SHIFT_CARRY_EN
    logic r_big;
    logic r_carry_out;
    logic w_cout;
    logic w_carry_final;

    // Last bit leaving the word during this step.
    always_comb begin
        w_cout = 1'b0;
        case (r_sel)
            c_OP_LSL, c_OP_ASL, c_OP_ROL: w_cout = r_work[5'(w_inv_n)];
            c_OP_LSR, c_OP_ASR, c_OP_ROR: w_cout = r_work[5'(w_n - 6'd1)];
            default:                      w_cout = 1'b0;
        endcase
    end

    assign w_carry_final = r_big ? ((r_sel == c_OP_ASR) ? r_sign : 1'b0) : w_cout;
    assign carry_out     = r_carry_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_work     <= 32'h0;
            r_sel      <= 3'd0;
            r_sign     <= 1'b0;
            r_count    <= 6'd0;
            r_out_data <= 32'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef SEQ_SHIFT_CARRY_EN
            r_big       <= 1'b0;
            r_carry_out <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_work  <= in_data;
                        r_sel   <= sel;
                        r_sign  <= in_data[31];
                        r_count <= w_eff_count;
`ifdef SEQ_SHIFT_CARRY_EN
                        r_big   <= (sel <= c_OP_ASR) && (k >= 6'd32);
`endif
                        if (w_eff_count != 6'd0) begin
                            r_state <= c_ST_SHIFT;
                            r_busy  <= 1'b1;
                        end else begin
                            // Zero count: result is ready in the very next cycle.
                            r_state    <= c_ST_DONE;
                            r_done     <= 1'b1;
                            r_out_data <= in_data;
`ifdef SEQ_SHIFT_CARRY_EN
                            r_carry_out <= 1'b0;
`endif
                        end
                    end
                end
                c_ST_SHIFT: begin
                    r_work  <= w_work_next;
                    r_count <= r_count - w_n;
                    if (w_last_step) begin
                        r_state    <= c_ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_out_data <= w_work_next;
`ifdef SEQ_SHIFT_CARRY_EN
                        r_carry_out <= w_carry_final;
`endif
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = r_out_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire
